// File: rtl/hwpe_ctrl_job_scheduler_pkg.sv
// Shared types and default sizes for the HWPE job scheduler.
//   ctx_state_e   : lifecycle of one register context
//   sched_state_e : engine dispatch FSM states
package hwpe_ctrl_job_scheduler_pkg;

    localparam int REGFILE_N_CONTEXT   = 2;
    localparam int REGFILE_N_MAX_CORES = 16;
    localparam int REGFILE_ID_WIDTH    = 8;

    typedef enum logic [1:0] {
        CTX_FREE      = 2'd0,
        CTX_ACQUIRED  = 2'd1,
        CTX_COMMITTED = 2'd2,
        CTX_RUNNING   = 2'd3
    } ctx_state_e;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_START = 2'd1,
        SCHED_RUN   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/hwpe_ctrl_job_scheduler.sv
// HWPE job scheduler: hands out register contexts to offloading cores
// (acquire/commit), dispatches committed contexts to the engine in ring
// order and routes the completion event back to the owning core.
//
// Ports
//   clk_i, rst_ni         clock, async active-low reset
//   clear_i               synchronous soft clear (same effect as reset)
//   acquire_req_i/src_i   core read of ACQUIRE and its core index
//   acquire_gnt_o/id_o    combinational grant and job ID for that read
//   pointer_ctx_o         context currently being programmed (wr_ptr)
//   commit_i              commit strobe for the acquired context
//   start_o               one-cycle engine start pulse
//   running_ctx_o         context being executed (rd_ptr)
//   busy_o                engine active or a committed job pending
//   done_i                engine completion pulse
//   evt_o                 one-cycle one-hot done event to the owner core
//   finished_cnt_o        saturating count of completed jobs
//
// Engine FSM
//   state       | meaning
//   SCHED_IDLE  | waiting for ctx[rd_ptr] to be committed
//   SCHED_START | start pulse out, context marked running
//   SCHED_RUN   | engine busy, waiting for done_i
module hwpe_ctrl_job_scheduler
    import hwpe_ctrl_job_scheduler_pkg::*;
#(
    parameter int N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int N_CORES   = REGFILE_N_MAX_CORES,
    parameter int ID_WIDTH  = REGFILE_ID_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         acquire_req_i,
    input  logic [$clog2(N_CORES)-1:0]   acquire_src_i,
    output logic                         acquire_gnt_o,
    output logic [ID_WIDTH-1:0]          acquire_id_o,
    output logic [$clog2(N_CONTEXT)-1:0] pointer_ctx_o,
    input  logic                         commit_i,
    output logic                         start_o,
    output logic [$clog2(N_CONTEXT)-1:0] running_ctx_o,
    output logic                         busy_o,
    input  logic                         done_i,
    output logic [N_CORES-1:0]           evt_o,
    output logic [7:0]                   finished_cnt_o
);

    localparam int PTR_W  = $clog2(N_CONTEXT);
    localparam int CORE_W = $clog2(N_CORES);

    ctx_state_e          ctx_state_q [N_CONTEXT];
    logic [CORE_W-1:0]   ctx_owner_q [N_CONTEXT];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ID_WIDTH-1:0] job_id_q;
    logic [N_CORES-1:0]  evt_q;
    logic [7:0]          finished_q;
    sched_state_e        state_q, state_d;

    logic any_acquired, any_committed;
    logic gnt, commit_ok, run_done;

    always_comb begin
        any_acquired  = 1'b0;
        any_committed = 1'b0;
        for (int i = 0; i < N_CONTEXT; i++) begin
            if (ctx_state_q[i] == CTX_ACQUIRED)  any_acquired  = 1'b1;
            if (ctx_state_q[i] == CTX_COMMITTED) any_committed = 1'b1;
        end
    end

    // Only one context may be in ACQUIRED at a time; a grant needs the write
    // slot free, which also covers the "all contexts busy" case.
    assign gnt       = acquire_req_i & ~clear_i & ~any_acquired
                     & (ctx_state_q[wr_ptr_q] == CTX_FREE);
    assign commit_ok = commit_i & (ctx_state_q[wr_ptr_q] == CTX_ACQUIRED);
    assign run_done  = (state_q == SCHED_RUN) & done_i;

    always_comb begin
        state_d = state_q;
        start_o = 1'b0;
        case (state_q)
            SCHED_IDLE: begin
                if (ctx_state_q[rd_ptr_q] == CTX_COMMITTED) state_d = SCHED_START;
            end
            SCHED_START: begin
                start_o = 1'b1;
                state_d = SCHED_RUN;
            end
            SCHED_RUN: begin
                if (done_i) state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCHED_IDLE;
        end else if (clear_i) begin
            state_q <= SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Acquire/commit act on wr_ptr, start/done on rd_ptr. They never touch the
    // same context in one cycle because each requires a different prior state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                ctx_state_q[i] <= CTX_FREE;
                ctx_owner_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            job_id_q   <= '0;
            evt_q      <= '0;
            finished_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                ctx_state_q[i] <= CTX_FREE;
                ctx_owner_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            job_id_q   <= '0;
            evt_q      <= '0;
            finished_q <= '0;
        end else begin
            evt_q <= '0;
            for (int i = 0; i < N_CONTEXT; i++) begin
                if (gnt && wr_ptr_q == PTR_W'(i)) begin
                    ctx_state_q[i] <= CTX_ACQUIRED;
                    ctx_owner_q[i] <= acquire_src_i;
                end else if (commit_ok && wr_ptr_q == PTR_W'(i)) begin
                    ctx_state_q[i] <= CTX_COMMITTED;
                end else if (state_q == SCHED_START && rd_ptr_q == PTR_W'(i)) begin
                    ctx_state_q[i] <= CTX_RUNNING;
                end else if (run_done && rd_ptr_q == PTR_W'(i)) begin
                    ctx_state_q[i] <= CTX_FREE;
                end
            end
            if (gnt)       job_id_q <= job_id_q + ID_WIDTH'(1);
            if (commit_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (run_done) begin
                rd_ptr_q                        <= rd_ptr_q + PTR_W'(1);
                evt_q[ctx_owner_q[rd_ptr_q]]    <= 1'b1;
                if (finished_q != 8'hFF) finished_q <= finished_q + 8'd1;
            end
        end
    end

    assign acquire_gnt_o  = gnt;
    assign acquire_id_o   = job_id_q;
    assign pointer_ctx_o  = wr_ptr_q;
    assign running_ctx_o  = rd_ptr_q;
    assign busy_o         = (state_q != SCHED_IDLE) | any_committed;
    assign evt_o          = evt_q;
    assign finished_cnt_o = finished_q;

endmodule
